pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush generator for the 5-stage cotm32 pipeline. It drives the i_stall/i_flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC hold.
- Resolves load-use hazards, multi-cycle EX ops, LSU bus wait and branch redirects.
- Sequences trap entry through a drain/flush FSM, so a trap never abandons an in-flight memory access.

Parameters:
XLEN_REGADDR, 5, register index width.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_id_rs1  in  5  ID-stage source register 1
i_id_rs2  in  5  ID-stage source register 2
i_id_use_rs1  in  1  ID instruction reads rs1
i_id_use_rs2  in  1  ID instruction reads rs2
i_idex_valid  in  1  ID/EX register holds a valid instruction
i_idex_is_load  in  1  ID/EX instruction is a load
i_idex_rd  in  5  ID/EX destination register
i_ex_busy  in  1  multi-cycle EX unit not done
i_ex_redirect  in  1  EX resolved taken branch/jump
i_mem_busy  in  1  LSU waiting on bus
i_trap_req  in  1  trap/exception raised at MEM
o_stall_pc  out  1  hold PC
o_stall_ifid / o_stall_idex / o_stall_exmem / o_stall_memwb  out  1 each  register stall
o_flush_ifid / o_flush_idex / o_flush_exmem / o_flush_memwb  out  1 each  register flush
o_trap_redirect  out  1  one-cycle pulse: PC <= trap vector

Behaviour:
- Reset:
  - Clocking and reset: i_clk, i_rst synchronous active-high.
  - While i_rst=1: state <= RUN; all flush outputs = 1; all stall outputs = 0; o_trap_redirect = 0.
- State register: RUN, DRAIN, TRAP_FLUSH. All outputs are combinational from state and inputs, so there is zero-cycle latency from an input to its effect.
- RUN, evaluated in strict priority order; only the highest-priority active condition applies:
  1. i_trap_req & i_mem_busy:
     - Stall PC, IF/ID, ID/EX and EX/MEM; flush MEM/WB.
     - Next state DRAIN.
  2. i_trap_req & !i_mem_busy: next state TRAP_FLUSH; no stall/flush this cycle.
  3. i_mem_busy:
     - Stall PC, IF/ID, ID/EX and EX/MEM; flush MEM/WB.
  4. i_ex_busy:
     - Stall PC, IF/ID and ID/EX; flush EX/MEM.
  5. i_ex_redirect:
     - Flush IF/ID and ID/EX; no stalls.
     - Redirect is acted on only when not stalled. Upstream keeps i_ex_redirect asserted while EX is held.
  6. Load-use:
     - Condition: i_idex_valid & i_idex_is_load & i_idex_rd!=0 & ((i_id_use_rs1 & rs1==rd) | (i_id_use_rs2 & rs2==rd)).
     - Stall PC and IF/ID; flush ID/EX (bubble). Lasts exactly 1 cycle per hazard.
  7. Otherwise: all outputs 0.
- DRAIN:
  - Stall PC and IF/ID through EX/MEM; flush MEM/WB.
  - When i_mem_busy=0, next state TRAP_FLUSH.
  - i_trap_req is ignored here; the trap is already latched by the state.
- TRAP_FLUSH:
  - Assert all four flushes and o_trap_redirect=1 for exactly one cycle; no stalls.
  - Next state RUN unconditionally. New i_trap_req is ignored in this cycle.
- Flush overrides stall on the same register. The block never asserts both; verification checks this.
- Redirect + load-use in the same cycle: the redirect wins; the load-use stall is suppressed.
- Reset mid-DRAIN: returns to RUN; the pending trap is discarded.

Optional Feature:
COTM32_PIPE_PERF_EN.
- Defined:
  - Adds o_perf_stall_cycles [31:0], incremented each cycle o_stall_pc=1.
  - Adds o_perf_flush_events [31:0], incremented each cycle any flush is asserted, excluding reset.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cotm32_pipeline_pkg:
  - pipe_ctrl_state_t enum {PC_RUN, PC_DRAIN, PC_TRAP_FLUSH}.
  - Packed struct pipe_ctrl_t bundling stall/flush bits per stage, driven as one output bundle internally.
- Sub-module load_use_detect: purely combinational rs/rd comparator, instantiated once.

Test Plan:
- Load x5 in ID/EX, ID reads rs2=5 -> 1 cycle: stall_pc=stall_ifid=flush_idex=1; next cycle all 0. Same with rd=0 -> no stall.
- i_mem_busy high 3 cycles -> stall_pc/ifid/idex/exmem=1 and flush_memwb=1 for exactly 3 cycles, then 0.
- i_trap_req with i_mem_busy high 2 cycles -> DRAIN 2 cycles, then TRAP_FLUSH: all flushes=1, o_trap_redirect=1 for 1 cycle, then RUN.
- i_trap_req with i_mem_busy=0 -> next cycle o_trap_redirect=1 plus all flushes; following cycle idle.
- i_ex_redirect and load-use hazard together -> flush_ifid=flush_idex=1, stall_pc=0; with i_ex_busy also high -> stall_pc/ifid/idex=1 and flush_exmem=1 only.
- Assert i_rst during DRAIN -> flushes all 1; after release, state RUN and no o_trap_redirect pulse.

Source files
------------

// File: rtl/cotm32_pipeline_pkg.sv
// cotm32_pipeline_pkg: shared types for the pipeline stall/flush controller.
//   pipe_ctrl_state_t : trap sequencing FSM states
//   pipe_ctrl_t       : per-stage stall/flush bundle plus trap redirect pulse
//   CTRL_*            : canned control bundles for each pipeline situation
//   any_flush()       : true when any pipeline register is being flushed
package cotm32_pipeline_pkg;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_DRAIN,
    PC_TRAP_FLUSH
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic stall_memwb;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
    logic flush_memwb;
    logic trap_redirect;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '0;

  // Freeze everything up to EX/MEM; bubble into WB while the LSU waits.
  localparam pipe_ctrl_t CTRL_MEM_WAIT = '{
    stall_pc: 1'b1, stall_ifid: 1'b1, stall_idex: 1'b1, stall_exmem: 1'b1,
    flush_memwb: 1'b1, default: 1'b0};

  // Freeze up to ID/EX; bubble into MEM while the EX unit iterates.
  localparam pipe_ctrl_t CTRL_EX_WAIT = '{
    stall_pc: 1'b1, stall_ifid: 1'b1, stall_idex: 1'b1,
    flush_exmem: 1'b1, default: 1'b0};

  localparam pipe_ctrl_t CTRL_REDIRECT = '{
    flush_ifid: 1'b1, flush_idex: 1'b1, default: 1'b0};

  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    stall_pc: 1'b1, stall_ifid: 1'b1, flush_idex: 1'b1, default: 1'b0};

  localparam pipe_ctrl_t CTRL_TRAP = '{
    flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b1, flush_memwb: 1'b1,
    trap_redirect: 1'b1, default: 1'b0};

  localparam pipe_ctrl_t CTRL_RESET = '{
    flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b1, flush_memwb: 1'b1,
    default: 1'b0};

  function automatic logic any_flush(input pipe_ctrl_t c);
    return c.flush_ifid | c.flush_idex | c.flush_exmem | c.flush_memwb;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
//   idex_valid/idex_is_load/idex_rd : load currently in EX
//   id_rs1/id_rs2/use_rs1/use_rs2   : sources read by the instruction in ID
//   hazard                          : ID needs a value the EX load has not produced yet
module load_use_detect #(
  parameter int unsigned XLEN_REGADDR = 5
) (
  input  logic                    idex_valid,
  input  logic                    idex_is_load,
  input  logic [XLEN_REGADDR-1:0] idex_rd,
  input  logic [XLEN_REGADDR-1:0] id_rs1,
  input  logic [XLEN_REGADDR-1:0] id_rs2,
  input  logic                    use_rs1,
  input  logic                    use_rs2,
  output logic                    hazard
);

  always_comb begin
    hazard = idex_valid & idex_is_load & (idex_rd != '0) &
             ((use_rs1 & (id_rs1 == idex_rd)) | (use_rs2 & (id_rs2 == idex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush generator for the 5-stage cotm32 pipeline.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_id_* / i_idex_*       : operands for load-use detection
//   i_ex_busy, i_ex_redirect: EX multi-cycle wait, taken branch/jump
//   i_mem_busy, i_trap_req  : LSU bus wait, trap raised at MEM
//   o_stall_* / o_flush_*   : per-register hold / bubble controls, PC hold
//   o_trap_redirect         : one-cycle pulse loading the trap vector
// Optional macro COTM32_PIPE_PERF_EN adds o_perf_stall_cycles and
// o_perf_flush_events (32-bit wrapping counters).
// Outputs are combinational from state and inputs (zero-cycle latency).
module pipeline_ctrl
  import cotm32_pipeline_pkg::*;
#(
  parameter int unsigned XLEN_REGADDR = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [XLEN_REGADDR-1:0] i_id_rs1,
  input  logic [XLEN_REGADDR-1:0] i_id_rs2,
  input  logic                    i_id_use_rs1,
  input  logic                    i_id_use_rs2,
  input  logic                    i_idex_valid,
  input  logic                    i_idex_is_load,
  input  logic [XLEN_REGADDR-1:0] i_idex_rd,
  input  logic                    i_ex_busy,
  input  logic                    i_ex_redirect,
  input  logic                    i_mem_busy,
  input  logic                    i_trap_req,
  output logic                    o_stall_pc,
  output logic                    o_stall_ifid,
  output logic                    o_stall_idex,
  output logic                    o_stall_exmem,
  output logic                    o_stall_memwb,
  output logic                    o_flush_ifid,
  output logic                    o_flush_idex,
  output logic                    o_flush_exmem,
  output logic                    o_flush_memwb,
`ifdef COTM32_PIPE_PERF_EN
  output logic [31:0]             o_perf_stall_cycles,
  output logic [31:0]             o_perf_flush_events,
`endif
  output logic                    o_trap_redirect
);

  pipe_ctrl_state_t state, state_next;
  pipe_ctrl_t       ctrl;
  logic             load_use;

  load_use_detect #(.XLEN_REGADDR(XLEN_REGADDR)) u_load_use (
    .idex_valid   (i_idex_valid),
    .idex_is_load (i_idex_is_load),
    .idex_rd      (i_idex_rd),
    .id_rs1       (i_id_rs1),
    .id_rs2       (i_id_rs2),
    .use_rs1      (i_id_use_rs1),
    .use_rs2      (i_id_use_rs2),
    .hazard       (load_use)
  );

  // Priority chain: only the highest active condition drives the bundle, so a
  // redirect naturally suppresses a same-cycle load-use stall.
  always_comb begin
    ctrl       = CTRL_IDLE;
    state_next = state;
    if (i_rst) begin
      ctrl       = CTRL_RESET;
      state_next = PC_RUN;
    end else begin
      unique case (state)
        PC_RUN: begin
          if (i_trap_req && i_mem_busy) begin
            ctrl       = CTRL_MEM_WAIT;
            state_next = PC_DRAIN;
          end else if (i_trap_req) begin
            state_next = PC_TRAP_FLUSH;
          end else if (i_mem_busy) begin
            ctrl = CTRL_MEM_WAIT;
          end else if (i_ex_busy) begin
            ctrl = CTRL_EX_WAIT;
          end else if (i_ex_redirect) begin
            ctrl = CTRL_REDIRECT;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        PC_DRAIN: begin
          ctrl = CTRL_MEM_WAIT;
          if (!i_mem_busy) state_next = PC_TRAP_FLUSH;
        end
        PC_TRAP_FLUSH: begin
          ctrl       = CTRL_TRAP;
          state_next = PC_RUN;
        end
        default: state_next = PC_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    state <= state_next;
  end

  always_comb begin
    o_stall_pc      = ctrl.stall_pc;
    o_stall_ifid    = ctrl.stall_ifid;
    o_stall_idex    = ctrl.stall_idex;
    o_stall_exmem   = ctrl.stall_exmem;
    o_stall_memwb   = ctrl.stall_memwb;
    o_flush_ifid    = ctrl.flush_ifid;
    o_flush_idex    = ctrl.flush_idex;
    o_flush_exmem   = ctrl.flush_exmem;
    o_flush_memwb   = ctrl.flush_memwb;
    o_trap_redirect = ctrl.trap_redirect;
  end

`ifdef COTM32_PIPE_PERF_EN
  // Flushes forced by reset are not counted: the counters clear instead.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_perf_stall_cycles <= '0;
      o_perf_flush_events <= '0;
    end else begin
      if (ctrl.stall_pc) o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
      if (any_flush(ctrl)) o_perf_flush_events <= o_perf_flush_events + 32'd1;
    end
  end
`endif

endmodule
